// File: rtl/inst_loader.sv
// Boot loader: assembles little-endian 32-bit words from a byte stream and writes them
// through the fetcher load port. Optional trailing XOR checksum: INST_LOADER_CHECKSUM_EN.

// One byte lane of the partial word being assembled.
module inst_loader_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (!rst || clr) q <= 8'h00;
    else if (we)     q <= din;
  end
endmodule

module inst_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             load,
  output logic [31:0]      load_addr,
  output logic [31:0]      load_inst,
  output logic             core_hold,
  output logic             done,
  output logic             error
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // Lanes 0..2 are buffered; lane 3 is taken straight off the bus on the last transfer.
  localparam int NUM_LANES = 3;

  logic [2:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt;
  logic [1:0]       byte_idx;
  logic [NUM_LANES-1:0][7:0] part;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic start_ok;
  logic len_zero;
  logic len_big;
  logic accept;
  logic recv_xfer;
  logic last_word;

  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_zero  = (len == '0);
  assign len_big   = 64'(len) > 64'(MAX_WORDS);
  assign accept    = start_ok && !len_zero && !len_big;
  assign recv_xfer = (state == S_RECV) && byte_valid;
  assign last_word = (LEN_W'(word_cnt + 1'b1) == len_q);

  // Outputs decode the registered state only; no path from byte_valid to byte_ready.
`ifdef INST_LOADER_CHECKSUM_EN
  assign byte_ready = (state == S_RECV) || (state == S_CHECK);
`else
  assign byte_ready = (state == S_RECV);
`endif
  assign load      = (state == S_WRITE);
  assign core_hold = (state != S_DONE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    inst_loader_lane u_lane (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .we  (recv_xfer && (byte_idx == 2'(i))),
      .din (byte_data),
      .q   (part[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      word_cnt  <= '0;
      byte_idx  <= 2'd0;
      load_addr <= 32'h0;
      load_inst <= 32'h0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_ok) begin
            if (len_zero)     state <= S_DONE;
            else if (len_big) state <= S_ERR;
            else begin
              len_q    <= len;
              word_cnt <= '0;
              byte_idx <= 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
              csum     <= 8'h00;
`endif
              state    <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
            if (byte_idx == 2'd3) begin
              load_inst <= {byte_data, part[2], part[1], part[0]};
              load_addr <= 32'({word_cnt, 2'b00});
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
          state    <= last_word ? S_CHECK : S_RECV;
`else
          state    <= last_word ? S_DONE : S_RECV;
`endif
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_valid) state <= (byte_data == csum) ? S_DONE : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: a word-level model queues expected writes, a monitor checks loads.
module tb_inst_loader;
  localparam int MAXW = 256;
  localparam int LW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, load, core_hold, done, error;
  logic [31:0]   load_addr, load_inst;

  inst_loader #(.MAX_WORDS(MAXW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .load(load), .load_addr(load_addr), .load_inst(load_inst),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] inst; } wr_t;

  int         checks = 0;
  int         passes = 0;
  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every load strobe must match the next expected write.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL load_unexpected: got addr %h inst %h expected no write", load_addr, load_inst);
      end else begin
        mon_e = exp_q.pop_front();
        chk("load_addr", load_addr, mon_e.addr);
        chk("load_inst", load_inst, mon_e.inst);
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic do_start(input int l);
    start = 1'b1;
    len   = LW'(l);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; n < 50; n++) begin
      rdy = byte_ready;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL byte_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 valid toggles each cycle, 2 random gaps.
  task automatic run_session(input int n, input int gap_mode, input bit bad);
    logic [7:0] cs;
    logic [7:0] sent;
    bit         exp_ok;
    wr_t        e;
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      e.addr = 32'(k * 4);
      e.inst = {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]};
      exp_q.push_back(e);
    end
    for (int i = 0; i < 4 * n; i++) cs = cs ^ prog[i];
    do_start(n);
    chk("recv_ready", {31'b0, byte_ready}, 32'd1);
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(prog[i]);
      if (i % 4 == 3) chk("load_after_4th", {31'b0, load}, 32'd1);
      else            chk("no_partial_load", {31'b0, load}, 32'd0);
      if (i != 4 * n - 1) begin
        if (gap_mode == 1)      @(negedge clk);
        else if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
`ifdef INST_LOADER_CHECKSUM_EN
    sent = bad ? 8'h00 : cs;
    send_byte(sent);
    exp_ok = (sent == cs);
`else
    sent = bad ? 8'h00 : cs;
    @(negedge clk);
    exp_ok = 1'b1;
`endif
    chk("done",      {31'b0, done},      {31'b0, exp_ok});
    chk("error",     {31'b0, error},     {31'b0, !exp_ok});
    chk("core_hold", {31'b0, core_hold}, {31'b0, !exp_ok});
    chk("drain",     32'(exp_q.size()),  32'd0);
  endtask

  task automatic load_directed();
    prog.delete();
    prog = '{8'h13, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'hE0, 8'h03};
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_core_hold",  {31'b0, core_hold},  32'd1);
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_load",       {31'b0, load},       32'd0);
    chk("rst_done",       {31'b0, done},       32'd0);
    chk("rst_error",      {31'b0, error},      32'd0);
    chk("rst_load_addr",  load_addr,           32'd0);
    chk("rst_load_inst",  load_inst,           32'd0);

    load_directed();
    run_session(2, 0, 1'b0);
    run_session(2, 1, 1'b0);

    // Oversize length, then zero length out of ERR.
    do_start(MAXW + 1);
    chk("big_error",      {31'b0, error},      32'd1);
    chk("big_core_hold",  {31'b0, core_hold},  32'd1);
    chk("big_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("big_done",       {31'b0, done},       32'd0);
    do_start(0);
    chk("zero_done",      {31'b0, done},       32'd1);
    chk("zero_core_hold", {31'b0, core_hold},  32'd0);
    chk("zero_error",     {31'b0, error},      32'd0);

    // Reset after two bytes of word 0: nothing may be written.
    do_start(2);
    send_byte(8'h13);
    send_byte(8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("abort_core_hold",  {31'b0, core_hold},  32'd1);
    chk("abort_load",       {31'b0, load},       32'd0);
    chk("abort_done",       {31'b0, done},       32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle_load",  {31'b0, load},       32'd0);
    chk("abort_idle_ready", {31'b0, byte_ready}, 32'd0);
    run_session(2, 0, 1'b0);

`ifdef INST_LOADER_CHECKSUM_EN
    run_session(2, 0, 1'b1);
    chk("badsum_done", {31'b0, done}, 32'd0);
`endif

    for (int s = 0; s < 10; s++) begin
      int n;
      n = $urandom_range(1, 6);
      prog.delete();
      for (int i = 0; i < 4 * n; i++) prog.push_back(8'($urandom));
      run_session(n, 2, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
